// File: rtl/mult8_seq4_ctrl_pkg.sv
// Shared constants for the sequential 8x8 multiplier: FSM encoding, step count,
// and the per-step nibble-select and shift tables.
package mult8_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam int STEPS = 4;

  // Partial-product weight for each step: lo*lo, lo*hi, hi*lo, hi*hi.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      2'd0:    sh = 4'd0;
      2'd1:    sh = 4'd4;
      2'd2:    sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

  // Returns {a_hi_sel, b_hi_sel} for each step.
  function automatic logic [1:0] step_nib_sel(input logic [1:0] step);
    logic [1:0] sel;
    case (step)
      2'd0:    sel = 2'b00;
      2'd1:    sel = 2'b01;
      2'd2:    sel = 2'b10;
      default: sel = 2'b11;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/mult8_seq4_ctrl_mult4.sv
// Combinational 4x4 unsigned multiplier; same interface as the mult4 used by
// the parallel 8x8 designs so a generated netlist can replace it directly.
module mult4_unit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  assign p = {4'd0, a} * {4'd0, b};

endmodule

// File: rtl/mult8_seq4_ctrl.sv
// 8x8 unsigned multiplier built from one shared 4x4 multiplier over four steps.
// Result in 5 cycles (MUL_REG=0) or 6 cycles (MUL_REG=1) after the operand handshake.
module mult8_seq4_ctrl
  import mult8_seq_pkg::*;
#(
  parameter int MUL_REG = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] P,
  output logic        busy
);

  // With the product register, one extra drain step flushes the last partial product.
  localparam logic [2:0] LAST_STEP = (MUL_REG != 0) ? 3'd4 : 3'd3;

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d, p_q, p_d;

  logic        hs, issue;
  logic [1:0]  sel;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  pp_raw, pp_use;
  logic [1:0]  pp_step;
  logic        pp_vld;
  logic [15:0] acc_sum;

  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign hs        = in_valid & in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign P         = p_q;
  assign issue     = (state_q == CALC) && (step_q < 3'(STEPS));

  always_comb begin
    sel   = step_nib_sel(step_q[1:0]);
    mul_a = 4'd0;
    mul_b = 4'd0;
    if (issue) begin
      mul_a = sel[1] ? a_q[7:4] : a_q[3:0];
      mul_b = sel[0] ? b_q[7:4] : b_q[3:0];
    end
  end

  mult4_unit u_mult4 (
    .a (mul_a),
    .b (mul_b),
    .p (pp_raw)
  );

  generate
    if (MUL_REG != 0) begin : g_pp_reg
      logic [7:0] pp_q;
      logic [1:0] pp_step_q;
      logic       pp_vld_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pp_q      <= 8'd0;
          pp_step_q <= 2'd0;
          pp_vld_q  <= 1'b0;
        end else begin
          pp_q      <= pp_raw;
          pp_step_q <= step_q[1:0];
          pp_vld_q  <= issue;
        end
      end

      assign pp_use  = pp_q;
      assign pp_step = pp_step_q;
      assign pp_vld  = pp_vld_q;
    end else begin : g_pp_comb
      assign pp_use  = pp_raw;
      assign pp_step = step_q[1:0];
      assign pp_vld  = issue;
    end
  endgenerate

  assign acc_sum = pp_vld ? (acc_q + ({8'd0, pp_use} << step_shift(pp_step))) : acc_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      CALC: begin
        acc_d = acc_sum;
        if (step_q == LAST_STEP) begin
          state_d = DONE;
          p_d     = acc_sum;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A handshake in DONE restarts straight into CALC with no IDLE bubble.
    if (hs) begin
      state_d = CALC;
      step_d  = 3'd0;
      a_d     = A;
      b_d     = B;
      acc_d   = 16'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
      p_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

endmodule

// File: tb/tb_mult8_seq4_ctrl.sv
// Directed and random checks of mult8_seq4_ctrl; both MUL_REG builds share stimulus,
// DUT0 is MUL_REG=0 and DUT1 is MUL_REG=1.
module tb_mult8_seq4_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  A = 8'd0;
  logic [7:0]  B = 8'd0;

  logic        in_ready0, out_valid0, busy0;
  logic [15:0] P0;
  logic        in_ready1, out_valid1, busy1;
  logic [15:0] P1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mult8_seq4_ctrl #(.MUL_REG(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .A(A), .B(B), .out_valid(out_valid0), .out_ready(out_ready),
    .P(P0), .busy(busy0)
  );

  mult8_seq4_ctrl #(.MUL_REG(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .A(A), .B(B), .out_valid(out_valid1), .out_ready(out_ready),
    .P(P1), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One operation with out_ready high; latencies counted in cycles after the handshake cycle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                       input string tag);
    int lat0 = 0;
    int lat1 = 0;
    int busy_cnt = 0;
    logic [15:0] p0 = 16'hxxxx;
    logic [15:0] p1 = 16'hxxxx;
    @(negedge clk);
    check({tag, "_rdy"}, {31'd0, in_ready0 & in_ready1}, 32'd1);
    A = a;
    B = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 8'($urandom);
    B = 8'($urandom);
    for (int k = 1; k <= 10; k++) begin
      if (out_valid0 && lat0 == 0) begin lat0 = k; p0 = P0; end
      if (out_valid1 && lat1 == 0) begin lat1 = k; p1 = P1; end
      if (busy0) busy_cnt++;
      @(posedge clk);
      #1;
    end
    check({tag, "_lat0"}, lat0, 32'd5);
    check({tag, "_lat1"}, lat1, 32'd6);
    check({tag, "_p0"}, {16'd0, p0}, {16'd0, exp});
    check({tag, "_p1"}, {16'd0, p1}, {16'd0, exp});
    check({tag, "_busy"}, busy_cnt, 32'd5);
  endtask

  logic [7:0]  pa [3];
  logic [7:0]  pb [3];
  logic [15:0] pe [3];
  logic [15:0] rp [3];
  int          rc [3];
  int          idx, nres, seen;
  logic        hs;
  logic [7:0]  ra, rb;

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state0", {in_ready0, out_valid0, busy0, P0}, {3'b100, 16'h0000});
    check("rst_state1", {in_ready1, out_valid1, busy1, P1}, {3'b100, 16'h0000});
    rst = 1'b0;

    do_op(8'h12, 8'h34, 16'h03A8, "t1_12x34");
    do_op(8'hFF, 8'hFF, 16'hFE01, "t2_ffxff");
    do_op(8'h00, 8'hA7, 16'h0000, "t2_00xa7");
    do_op(8'h80, 8'h02, 16'h0100, "t2_80x02");

    // Backpressure: result held while out_ready is low, new operands ignored.
    @(negedge clk);
    out_ready = 1'b0;
    A = 8'h0F;
    B = 8'hF0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && !out_valid0; k++) begin
      @(posedge clk);
      #1;
    end
    check("bp_valid", {31'd0, out_valid0}, 32'd1);
    A = 8'h11;
    B = 8'h11;
    in_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      check("bp_hold", {out_valid0, in_ready0, P0}, {2'b10, 16'h0E10});
      @(posedge clk);
      #1;
    end
    check("bp_hold1", {out_valid1, in_ready1, P1}, {2'b10, 16'h0E10});
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {out_valid0, busy0, P0}, {2'b00, 16'h0E10});

    // Back-to-back traffic with in_valid held high.
    pa[0] = 8'd3;   pb[0] = 8'd5;   pe[0] = 16'h000F;
    pa[1] = 8'd200; pb[1] = 8'd100; pe[1] = 16'h4E20;
    pa[2] = 8'd17;  pb[2] = 8'd17;  pe[2] = 16'h0121;
    for (int i = 0; i < 3; i++) begin rp[i] = 16'hxxxx; rc[i] = -100; end
    idx = 0;
    nres = 0;
    @(negedge clk);
    A = pa[0];
    B = pb[0];
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 40 && nres < 3; cyc++) begin
      hs = in_valid && in_ready0;
      @(posedge clk);
      #1;
      if (out_valid0) begin rp[nres] = P0; rc[nres] = cyc; nres++; end
      if (hs) begin
        idx++;
        if (idx < 3) begin A = pa[idx]; B = pb[idx]; end
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_count", nres, 32'd3);
    for (int i = 0; i < 3; i++) check("b2b_p", {16'd0, rp[i]}, {16'd0, pe[i]});
    check("b2b_gap01", rc[1] - rc[0], 32'd5);
    check("b2b_gap12", rc[2] - rc[1], 32'd5);
    repeat (10) @(posedge clk);

    // Reset asserted during CALC step 2 aborts the operation.
    @(negedge clk);
    A = 8'hC3;
    B = 8'h5A;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("abort_state", {in_ready0, out_valid0, busy0, P0}, {3'b100, 16'h0000});
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (out_valid0 || out_valid1) seen++;
    end
    check("abort_no_result", seen, 32'd0);
    do_op(8'h02, 8'h03, 16'h0006, "t5_02x03");

    // Random pairs against the arithmetic product, both builds.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      do_op(ra, rb, 16'(ra) * 16'(rb), "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
